// File: rtl/xc_pmul_seq.sv
// xc_pmul_seq: multi-cycle packed (lane-sliced) multiplier for the MALU.
// Lanes of 16/8/4/2 bits are selected by a one-hot width code.
// Each lane keeps a 2W-bit accumulator, and BPC multiplier bits are retired per cycle.
// The first step is taken on the accept edge, so the result is visible W/BPC cycles
// after the request cycle.
// Optional feature: define XC_PMUL_SEQ_CLMUL_EN to build the carry-less (XOR) path.
// Without it, req_clmul=1 is reported as an error.
module xc_pmul_seq #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [3:0]      req_pw,
    input  logic            req_hi,
    input  logic            req_clmul,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic                r_live;      // low only until the first clock after reset
    logic [2*XLEN-1:0]   r_acc;       // per-lane 2W-bit accumulators
    logic [2*XLEN-1:0]   r_mcand;     // per-lane zero-extended multiplicand, shifted up
    logic [XLEN-1:0]     r_mult;      // per-lane multiplier, shifted down
    logic [3:0]          r_pw;
    logic                r_hi;
    logic [4:0]          r_cnt;
    logic [XLEN-1:0]     r_result;
    logic                r_err;
`ifdef XC_PMUL_SEQ_CLMUL_EN
    logic                r_clmul;
`endif

    logic                w_run;
    logic [3:0]          w_pw;
    logic                w_hi;
`ifdef XC_PMUL_SEQ_CLMUL_EN
    logic                w_clmul;
`endif
    logic [1:0]          w_sel;
    logic [4:0]          w_steps;
    logic                w_step_done;
    logic                w_bad;
    logic                w_req_ready;
    logic                w_accept;

    logic [3:0][2*XLEN-1:0] w_acc_n;
    logic [3:0][2*XLEN-1:0] w_mcand_n;
    logic [3:0][XLEN-1:0]   w_mult_n;
    logic [3:0][XLEN-1:0]   w_res_n;
    logic [2*XLEN-1:0]      w_acc_sel;
    logic [2*XLEN-1:0]      w_mcand_sel;
    logic [XLEN-1:0]        w_mult_sel;
    logic [XLEN-1:0]        w_res_sel;

    // In RUN the step works on the latched state; otherwise it works on the incoming request.
    assign w_run   = (r_state == S_RUN);
    assign w_pw    = w_run ? r_pw : req_pw;
    assign w_hi    = w_run ? r_hi : req_hi;
`ifdef XC_PMUL_SEQ_CLMUL_EN
    assign w_clmul = w_run ? r_clmul : req_clmul;
`endif

    // One datapath per lane width; lane carries are confined to their own 2W-bit slice.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_width
            localparam int W = 2 << gi;
            if (W >= BPC) begin : g_on
                for (genvar gl = 0; gl < XLEN / W; gl++) begin : g_lane
                    logic [2*W-1:0] w_acc_in;
                    logic [2*W-1:0] w_mcand_in;
                    logic [2*W-1:0] w_sum;
                    logic [W-1:0]   w_mult_in;

                    assign w_acc_in   = w_run ? r_acc[2*W*gl +: 2*W] : '0;
                    assign w_mcand_in = w_run ? r_mcand[2*W*gl +: 2*W]
                                              : {{W{1'b0}}, req_rs1[W*gl +: W]};
                    assign w_mult_in  = w_run ? r_mult[W*gl +: W] : req_rs2[W*gl +: W];

                    // Retire BPC multiplier bits: add (or XOR) the shifted multiplicand per set bit.
                    always_comb begin
                        w_sum = w_acc_in;
                        for (int j = 0; j < BPC; j++) begin
                            if (w_mult_in[j]) begin
`ifdef XC_PMUL_SEQ_CLMUL_EN
                                if (w_clmul)
                                    w_sum = w_sum ^ (w_mcand_in << j);
                                else
                                    w_sum = w_sum + (w_mcand_in << j);
`else
                                w_sum = w_sum + (w_mcand_in << j);
`endif
                            end
                        end
                    end

                    assign w_acc_n[gi][2*W*gl +: 2*W]   = w_sum;
                    assign w_mcand_n[gi][2*W*gl +: 2*W] = w_mcand_in << BPC;
                    assign w_mult_n[gi][W*gl +: W]      = w_mult_in >> BPC;
                    assign w_res_n[gi][W*gl +: W]       = w_hi ? w_sum[2*W-1:W] : w_sum[W-1:0];
                end
            end else begin : g_off
                // Lanes narrower than BPC are rejected as unsupported at accept.
                assign w_acc_n[gi]   = '0;
                assign w_mcand_n[gi] = '0;
                assign w_mult_n[gi]  = '0;
                assign w_res_n[gi]   = '0;
            end
        end
    endgenerate

    // Decode the lane width into a datapath select and the number of steps it needs.
    always_comb begin
        w_sel   = 2'd0;
        w_steps = 5'd0;
        case (w_pw)
            4'b0001: begin w_sel = 2'd0; w_steps = 5'(2 / BPC);  end
            4'b0010: begin w_sel = 2'd1; w_steps = 5'(4 / BPC);  end
            4'b0100: begin w_sel = 2'd2; w_steps = 5'(8 / BPC);  end
            4'b1000: begin w_sel = 2'd3; w_steps = 5'(16 / BPC); end
            default: begin w_sel = 2'd0; w_steps = 5'd0;        end
        endcase
    end

    assign w_acc_sel   = w_acc_n[w_sel];
    assign w_mcand_sel = w_mcand_n[w_sel];
    assign w_mult_sel  = w_mult_n[w_sel];
    assign w_res_sel   = w_res_n[w_sel];

    assign w_step_done = w_run ? ((r_cnt + 5'd1) == w_steps) : (w_steps == 5'd1);

`ifdef XC_PMUL_SEQ_CLMUL_EN
    assign w_bad = !((req_pw == 4'b0001) || (req_pw == 4'b0010) ||
                     (req_pw == 4'b0100) || (req_pw == 4'b1000)) ||
                   (req_pw[0] && (BPC > 2));
`else
    assign w_bad = !((req_pw == 4'b0001) || (req_pw == 4'b0010) ||
                     (req_pw == 4'b0100) || (req_pw == 4'b1000)) ||
                   (req_pw[0] && (BPC > 2)) || req_clmul;
`endif

    assign w_req_ready = r_live && ((r_state == S_IDLE) || ((r_state == S_DONE) && rsp_ready));
    assign w_accept    = req_valid && w_req_ready;

    assign req_ready  = w_req_ready;
    assign rsp_valid  = (r_state == S_DONE);
    assign rsp_result = r_result;
    assign rsp_err    = r_err;

    // Control FSM and datapath registers; flush overrides everything except reset.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state  <= S_IDLE;
            r_live   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mult   <= '0;
            r_pw     <= '0;
            r_hi     <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
`ifdef XC_PMUL_SEQ_CLMUL_EN
            r_clmul  <= 1'b0;
`endif
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_pw <= req_pw;
                r_hi <= req_hi;
`ifdef XC_PMUL_SEQ_CLMUL_EN
                r_clmul <= req_clmul;
`endif
                if (w_bad) begin
                    r_state  <= S_DONE;
                    r_result <= '0;
                    r_err    <= 1'b1;
                end else begin
                    r_err   <= 1'b0;
                    r_acc   <= w_acc_sel;
                    r_mcand <= w_mcand_sel;
                    r_mult  <= w_mult_sel;
                    r_cnt   <= 5'd1;
                    if (w_step_done) begin
                        r_state  <= S_DONE;
                        r_result <= w_res_sel;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_acc   <= w_acc_sel;
                        r_mcand <= w_mcand_sel;
                        r_mult  <= w_mult_sel;
                        r_cnt   <= r_cnt + 5'd1;
                        if (w_step_done) begin
                            r_state  <= S_DONE;
                            r_result <= w_res_sel;
                        end
                    end
                    S_DONE: begin
                        if (rsp_ready)
                            r_state <= S_IDLE;
                    end
                    S_IDLE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xc_pmul_seq.sv
// tb_xc_pmul_seq: table vectors, randomized requests against a lane-arithmetic
// reference model, and hand-written backpressure/flush/reset sequences.
// Instance 0 uses BPC=1 and instance 1 uses BPC=2. Both instances share the operand inputs.
module tb_xc_pmul_seq;

    logic g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    logic            g_reset;
    logic            flush;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [1:0]      rsp_err;
    logic [1:0][31:0] rsp_result;
    logic [31:0]     req_rs1;
    logic [31:0]     req_rs2;
    logic [3:0]      req_pw;
    logic            req_hi;
    logic            req_clmul;

    int n_tests = 0;
    int n_fail  = 0;

    xc_pmul_seq #(.XLEN(32), .BPC(1)) u_dut0 (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pw(req_pw),
        .req_hi(req_hi), .req_clmul(req_clmul),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_result(rsp_result[0]), .rsp_err(rsp_err[0])
    );

    xc_pmul_seq #(.XLEN(32), .BPC(2)) u_dut1 (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pw(req_pw),
        .req_hi(req_hi), .req_clmul(req_clmul),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_result(rsp_result[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        int          d;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  pw;
        logic        hi;
        logic        clmul;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: split into lanes, multiply (or carry-less multiply) each lane, then pick a half.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] pw, input logic hi, input logic cl,
                                  input int bpc, output logic [31:0] res,
                                  output logic err, output int lat);
        int w;
        longint unsigned mask;
        res = '0;
        err = 1'b0;
        lat = 1;
        case (pw)
            4'b0001: w = 2;
            4'b0010: w = 4;
            4'b0100: w = 8;
            4'b1000: w = 16;
            default: w = 0;
        endcase
        if (w == 0 || w < bpc) err = 1'b1;
`ifndef XC_PMUL_SEQ_CLMUL_EN
        if (cl) err = 1'b1;
`endif
        if (!err) begin
            lat  = w / bpc;
            mask = (64'd1 << w) - 64'd1;
            for (int l = 0; l < 32 / w; l++) begin
                longint unsigned x, y, p, lane;
                x = (longint'(a) >> (l * w)) & mask;
                y = (longint'(b) >> (l * w)) & mask;
                if (cl) begin
                    p = 0;
                    for (int i = 0; i < w; i++)
                        if (((y >> i) & 64'd1) != 0) p = p ^ (x << i);
                end else begin
                    p = x * y;
                end
                lane = hi ? ((p >> w) & mask) : (p & mask);
                res  = res | 32'(lane << (l * w));
            end
        end
    endfunction

    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] pw, input logic hi, input logic cl,
                       input logic [31:0] e_res, input logic e_err, input int e_lat,
                       input string name);
        int lat;
        check({name, "/req_ready"}, 64'(req_ready[d]), 64'd1);
        req_rs1 = a; req_rs2 = b; req_pw = pw; req_hi = hi; req_clmul = cl;
        req_valid[d] = 1'b1;
        @(posedge g_clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 200) begin
            @(posedge g_clk); #1;
            lat++;
        end
        check({name, "/latency"}, 64'(lat), 64'(e_lat));
        check({name, "/result"}, 64'(rsp_result[d]), 64'(e_res));
        check({name, "/err"}, 64'(rsp_err[d]), 64'(e_err));
        $display("[TB] %s dut%0d rs1=%h rs2=%h pw=%b hi=%0d clmul=%0d -> result=%h err=%0d lat=%0d",
                 name, d, a, b, pw, hi, cl, rsp_result[d], rsp_err[d], lat);
        rsp_ready[d] = 1'b1;
        @(posedge g_clk); #1;
        rsp_ready[d] = 1'b0;
        check({name, "/released"}, 64'(rsp_valid[d]), 64'd0);
    endtask

    task automatic watch_quiet(input int d, input string name);
        int seen;
        seen = 0;
        repeat (20) begin
            @(posedge g_clk); #1;
            if (rsp_valid[d]) seen++;
        end
        check({name, "/no_rsp"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, e_res;
        logic [3:0]  pw;
        logic        hi, cl, e_err;
        int          d, r, e_lat;

        g_reset = 1'b1; flush = 1'b0;
        req_valid = '0; rsp_ready = '0;
        req_rs1 = '0; req_rs2 = '0; req_pw = '0; req_hi = 1'b0; req_clmul = 1'b0;

        // Reset values
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset/req_ready", 64'(req_ready[i]), 64'd0);
            check("reset/rsp_valid", 64'(rsp_valid[i]), 64'd0);
            check("reset/rsp_result", 64'(rsp_result[i]), 64'd0);
            check("reset/rsp_err", 64'(rsp_err[i]), 64'd0);
        end
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
        @(posedge g_clk); #1;
        check("post_reset/req_ready0", 64'(req_ready[0]), 64'd1);
        check("post_reset/req_ready1", 64'(req_ready[1]), 64'd1);

        // Directed table
        vecs.push_back('{0, 32'h0003FFFF, 32'h0005FFFF, 4'b1000, 1'b0, 1'b0, 32'h000F0001, 1'b0, 16, "pw16_lo"});
        vecs.push_back('{0, 32'h0003FFFF, 32'h0005FFFF, 4'b1000, 1'b1, 1'b0, 32'h0000FFFE, 1'b0, 16, "pw16_hi"});
        vecs.push_back('{1, 32'h0003FFFF, 32'h0005FFFF, 4'b1000, 1'b0, 1'b0, 32'h000F0001, 1'b0, 8,  "pw16_lo_bpc2"});
        vecs.push_back('{0, 32'h102030FF, 32'h100204FF, 4'b0100, 1'b0, 1'b0, 32'h0040C001, 1'b0, 8,  "pw8_lo"});
        vecs.push_back('{0, 32'h102030FF, 32'h100204FF, 4'b0100, 1'b1, 1'b0, 32'h010000FE, 1'b0, 8,  "pw8_hi"});
        vecs.push_back('{0, 32'h33333333, 32'h33333333, 4'b0010, 1'b0, 1'b0, 32'h99999999, 1'b0, 4,  "pw4_int"});
`ifdef XC_PMUL_SEQ_CLMUL_EN
        vecs.push_back('{0, 32'h33333333, 32'h33333333, 4'b0010, 1'b0, 1'b1, 32'h55555555, 1'b0, 4,  "pw4_clmul"});
`else
        vecs.push_back('{0, 32'h33333333, 32'h33333333, 4'b0010, 1'b0, 1'b1, 32'h00000000, 1'b1, 1,  "pw4_clmul_off"});
`endif
        vecs.push_back('{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001, 1'b0, 1'b0, 32'h55555555, 1'b0, 1,  "pw2_lo_bpc2"});
        vecs.push_back('{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 1,  "pw2_hi_bpc2"});
        vecs.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 2,  "pw2_hi_bpc1"});
        vecs.push_back('{0, 32'h12345678, 32'h9ABCDEF0, 4'b0110, 1'b0, 1'b0, 32'h00000000, 1'b1, 1,  "pw_multihot"});
        vecs.push_back('{1, 32'h12345678, 32'h9ABCDEF0, 4'b0000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1,  "pw_zero"});
        for (int i = 0; i < vecs.size(); i++)
            txn(vecs[i].d, vecs[i].rs1, vecs[i].rs2, vecs[i].pw, vecs[i].hi, vecs[i].clmul,
                vecs[i].exp_res, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].name);

        // Randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            d  = int'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            r  = int'($urandom_range(0, 9));
            pw = (r < 9) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
            hi = 1'($urandom_range(0, 1));
            cl = 1'($urandom_range(0, 1));
            model(a, b, pw, hi, cl, d + 1, e_res, e_err, e_lat);
            txn(d, a, b, pw, hi, cl, e_res, e_err, e_lat, "rand");
        end

        // Backpressure, then back-to-back accept in DONE
        req_rs1 = 32'h102030FF; req_rs2 = 32'h100204FF; req_pw = 4'b0100; req_hi = 1'b1; req_clmul = 1'b0;
        req_valid[0] = 1'b1;
        @(posedge g_clk); #1;
        req_valid[0] = 1'b0;
        r = 1;
        while (!rsp_valid[0] && r < 200) begin @(posedge g_clk); #1; r++; end
        check("bp/latency", 64'(r), 64'd8);
        repeat (5) begin
            @(posedge g_clk); #1;
            check("bp/valid_held", 64'(rsp_valid[0]), 64'd1);
            check("bp/result_held", 64'(rsp_result[0]), 64'h010000FE);
            check("bp/req_ready_low", 64'(req_ready[0]), 64'd0);
        end
        $display("[TB] backpressure held result=%h for 5 cycles", rsp_result[0]);
        rsp_ready[0] = 1'b1; req_valid[0] = 1'b1;
        req_rs1 = 32'h0003FFFF; req_rs2 = 32'h0005FFFF; req_pw = 4'b1000; req_hi = 1'b0;
        #1;
        check("b2b/req_ready", 64'(req_ready[0]), 64'd1);
        @(posedge g_clk); #1;
        rsp_ready[0] = 1'b0; req_valid[0] = 1'b0;
        check("b2b/in_run", 64'(rsp_valid[0]), 64'd0);
        check("b2b/busy", 64'(req_ready[0]), 64'd0);
        r = 1;
        while (!rsp_valid[0] && r < 200) begin @(posedge g_clk); #1; r++; end
        check("b2b/latency", 64'(r), 64'd16);
        check("b2b/result", 64'(rsp_result[0]), 64'h000F0001);
        $display("[TB] back-to-back second result=%h lat=%0d", rsp_result[0], r);
        rsp_ready[0] = 1'b1;
        @(posedge g_clk); #1;
        rsp_ready[0] = 1'b0;

        // Flush at RUN cycle 7
        req_valid[0] = 1'b1;
        @(posedge g_clk); #1;
        req_valid[0] = 1'b0;
        repeat (6) begin @(posedge g_clk); #1; end
        flush = 1'b1;
        @(posedge g_clk); #1;
        flush = 1'b0;
        check("flush/rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("flush/idle", 64'(req_ready[0]), 64'd1);
        watch_quiet(0, "flush");
        $display("[TB] flush at RUN cycle 7: unit back to idle");

        // Flush coinciding with a request in IDLE drops it
        flush = 1'b1; req_valid[0] = 1'b1;
        @(posedge g_clk); #1;
        flush = 1'b0; req_valid[0] = 1'b0;
        check("flush_req/idle", 64'(req_ready[0]), 64'd1);
        watch_quiet(0, "flush_req");
        $display("[TB] flush with req_valid in IDLE: request dropped");
        txn(0, 32'h0003FFFF, 32'h0005FFFF, 4'b1000, 1'b1, 1'b0, 32'h0000FFFE, 1'b0, 16, "after_flush");

        // Asynchronous reset mid-RUN
        req_valid[0] = 1'b1;
        @(posedge g_clk); #1;
        req_valid[0] = 1'b0;
        repeat (4) begin @(posedge g_clk); #1; end
        g_reset = 1'b1;
        #1;
        check("areset/req_ready", 64'(req_ready[0]), 64'd0);
        check("areset/rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("areset/rsp_result", 64'(rsp_result[0]), 64'd0);
        check("areset/rsp_err", 64'(rsp_err[0]), 64'd0);
        @(negedge g_clk);
        g_reset = 1'b0;
        @(posedge g_clk); #1;
        check("areset/ready_after", 64'(req_ready[0]), 64'd1);
        watch_quiet(0, "areset");
        $display("[TB] reset mid-RUN: outputs cleared, no response");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
